// File: rtl/board_vga_renderer.sv
// Renders a 16x16 Game of Life board as a 640x480@60Hz VGA image, with one board snapshot per frame.
// Optional macro GRID_LINES_EN draws a grey grid on the first pixel row/column of every cell.
module board_vga_renderer #(
    parameter int CLK_DIV = 4,
    parameter int CELL_PX = 24,
    parameter int X_OFF   = 128,
    parameter int Y_OFF   = 48
) (
    input  logic         ClkPort,
    input  logic         reset,
    input  logic [255:0] board_i,
    output logic         hsync,
    output logic         vsync,
    output logic [3:0]   vga_r,
    output logic [3:0]   vga_g,
    output logic [3:0]   vga_b,
    output logic         frame_start_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SUB_W = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);

    localparam logic [9:0] H_LAST = 10'd799;
    localparam logic [9:0] V_LAST = 10'd524;
    localparam logic [9:0] H_ACT  = 10'd640;
    localparam logic [9:0] V_ACT  = 10'd480;
    localparam logic [9:0] HS_LO  = 10'd656;
    localparam logic [9:0] HS_HI  = 10'd751;
    localparam logic [9:0] VS_LO  = 10'd490;
    localparam logic [9:0] VS_HI  = 10'd491;
    localparam logic [9:0] X_LO   = 10'(X_OFF);
    localparam logic [9:0] X_HI   = 10'(X_OFF + 16 * CELL_PX);
    localparam logic [9:0] Y_LO   = 10'(Y_OFF);
    localparam logic [9:0] Y_HI   = 10'(Y_OFF + 16 * CELL_PX);

    localparam logic [11:0] RGB_BLANK = 12'h000;
    localparam logic [11:0] RGB_BACK  = 12'h004;
    localparam logic [11:0] RGB_LIVE  = 12'h0F0;
    localparam logic [11:0] RGB_DEAD  = 12'h111;
    localparam logic [11:0] RGB_GRID  = 12'h444;

    logic [DIV_W-1:0] div_reg, div_next;
    logic [9:0]       hcnt_reg, hcnt_next;
    logic [9:0]       vcnt_reg, vcnt_next;
    logic [SUB_W-1:0] col_sub_reg, col_sub_next;
    logic [3:0]       col_idx_reg, col_idx_next;
    logic [SUB_W-1:0] row_sub_reg, row_sub_next;
    logic [3:0]       row_idx_reg, row_idx_next;
    logic [255:0]     snap_reg;
    logic             hsync_reg, hsync_next;
    logic             vsync_reg, vsync_next;
    logic [11:0]      rgb_reg, rgb_next;

    logic tick;
    logic line_end;
    logic in_x;
    logic in_y;
    logic active;
    logic snap_now;
    logic live;

    assign tick     = (div_reg == DIV_LAST);
    assign line_end = (hcnt_reg == H_LAST);
    assign in_x     = (hcnt_reg >= X_LO) && (hcnt_reg < X_HI);
    assign in_y     = (vcnt_reg >= Y_LO) && (vcnt_reg < Y_HI);
    assign active   = (hcnt_reg < H_ACT) && (vcnt_reg < V_ACT);
    assign snap_now = tick && (hcnt_reg == 10'd0) && (vcnt_reg == V_ACT);
    assign live     = snap_reg[{row_idx_reg, col_idx_reg}];

    // Counter advance. Cell sub-counters are held at zero outside the board so
    // they start cleanly at the board edge; the index wraps 15->0 on exit.
    always_comb begin
        div_next     = tick ? '0 : div_reg + DIV_W'(1);
        hcnt_next    = hcnt_reg;
        vcnt_next    = vcnt_reg;
        col_sub_next = col_sub_reg;
        col_idx_next = col_idx_reg;
        row_sub_next = row_sub_reg;
        row_idx_next = row_idx_reg;
        if (tick) begin
            hcnt_next = line_end ? 10'd0 : hcnt_reg + 10'd1;
            if (in_x) begin
                col_sub_next = (col_sub_reg == SUB_LAST) ? '0 : col_sub_reg + SUB_W'(1);
                if (col_sub_reg == SUB_LAST) begin
                    col_idx_next = col_idx_reg + 4'd1;
                end
            end else begin
                col_sub_next = '0;
                col_idx_next = 4'd0;
            end
            if (line_end) begin
                vcnt_next = (vcnt_reg == V_LAST) ? 10'd0 : vcnt_reg + 10'd1;
                if (in_y) begin
                    row_sub_next = (row_sub_reg == SUB_LAST) ? '0 : row_sub_reg + SUB_W'(1);
                    if (row_sub_reg == SUB_LAST) begin
                        row_idx_next = row_idx_reg + 4'd1;
                    end
                end else begin
                    row_sub_next = '0;
                    row_idx_next = 4'd0;
                end
            end
        end
    end

    // Pixel colour and sync, computed from the pre-increment counters.
    always_comb begin
        hsync_next = !((hcnt_reg >= HS_LO) && (hcnt_reg <= HS_HI));
        vsync_next = !((vcnt_reg >= VS_LO) && (vcnt_reg <= VS_HI));
        rgb_next   = RGB_BLANK;
        if (active) begin
            if (in_x && in_y) begin
`ifdef GRID_LINES_EN
                if ((col_sub_reg == '0) || (row_sub_reg == '0)) begin
                    rgb_next = RGB_GRID;
                end else begin
                    rgb_next = live ? RGB_LIVE : RGB_DEAD;
                end
`else
                rgb_next = live ? RGB_LIVE : RGB_DEAD;
`endif
            end else begin
                rgb_next = RGB_BACK;
            end
        end
    end

    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            div_reg     <= '0;
            hcnt_reg    <= 10'd0;
            vcnt_reg    <= 10'd0;
            col_sub_reg <= '0;
            col_idx_reg <= 4'd0;
            row_sub_reg <= '0;
            row_idx_reg <= 4'd0;
            snap_reg    <= '0;
            hsync_reg   <= 1'b1;
            vsync_reg   <= 1'b1;
            rgb_reg     <= RGB_BLANK;
        end else begin
            div_reg     <= div_next;
            hcnt_reg    <= hcnt_next;
            vcnt_reg    <= vcnt_next;
            col_sub_reg <= col_sub_next;
            col_idx_reg <= col_idx_next;
            row_sub_reg <= row_sub_next;
            row_idx_reg <= row_idx_next;
            if (tick) begin
                hsync_reg <= hsync_next;
                vsync_reg <= vsync_next;
                rgb_reg   <= rgb_next;
            end
            if (snap_now) begin
                snap_reg <= board_i;
            end
        end
    end

    assign hsync         = hsync_reg;
    assign vsync         = vsync_reg;
    assign vga_r         = rgb_reg[11:8];
    assign vga_g         = rgb_reg[7:4];
    assign vga_b         = rgb_reg[3:0];
    assign frame_start_o = snap_now;

endmodule

// File: tb/tb_board_vga_renderer.sv
// Self-checking bench for board_vga_renderer: pixel-arithmetic reference model plus probe tables.
module tb_board_vga_renderer;

    localparam int DIV   = 2;
    localparam int FRAME = 800 * 525;
`ifdef GRID_LINES_EN
    localparam bit GRID = 1'b1;
`else
    localparam bit GRID = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [255:0] board_i = '0;
    logic         hsync, vsync, frame_start_o;
    logic [3:0]   vga_r, vga_g, vga_b;

    always #5 clk = ~clk;

    board_vga_renderer #(.CLK_DIV(DIV)) dut (
        .ClkPort(clk),
        .reset(reset),
        .board_i(board_i),
        .hsync(hsync),
        .vsync(vsync),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .frame_start_o(frame_start_o)
    );

    int checks = 0;
    int fails  = 0;

    // Expected colour of screen pixel (h,v) given the frame's board snapshot.
    function automatic logic [11:0] ref_pixel(int h, int v, logic [255:0] snap);
        if (h >= 640 || v >= 480) return 12'h000;
        if (h < 128 || h >= 512 || v < 48 || v >= 432) return 12'h004;
        if (GRID && (((h - 128) % 24 == 0) || ((v - 48) % 24 == 0))) return 12'h444;
        return snap[((v - 48) / 24) * 16 + (h - 128) / 24] ? 12'h0F0 : 12'h111;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: k counts clock edges since reset release; every DIV-th
    // edge a new pixel index q becomes visible on the outputs.
    int           k;
    int           nq, nh, nv;
    logic         ntick;
    logic [255:0] snap_m;
    logic         exp_hs, exp_vs, exp_tick;
    logic [11:0]  exp_rgb;
    int           exp_h, exp_v, exp_q;

    assign ntick = ((k + 1) % DIV == 0);
    assign nq    = (k + 1) / DIV - 1;
    assign nh    = nq % 800;
    assign nv    = (nq / 800) % 525;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k        <= 0;
            snap_m   <= '0;
            exp_hs   <= 1'b1;
            exp_vs   <= 1'b1;
            exp_rgb  <= 12'h000;
            exp_tick <= 1'b0;
            exp_h    <= 0;
            exp_v    <= 0;
            exp_q    <= -1;
        end else begin
            k        <= k + 1;
            exp_tick <= ntick;
            if (ntick) begin
                exp_q   <= nq;
                exp_h   <= nh;
                exp_v   <= nv;
                exp_hs  <= !(nh >= 656 && nh <= 751);
                exp_vs  <= !(nv == 490 || nv == 491);
                exp_rgb <= ref_pixel(nh, nv, snap_m);
                if (nh == 0 && nv == 480) snap_m <= board_i;
            end
        end
    end

    int          cyc = 0;
    int          line_err = 0;
    int          f_h;
    logic [14:0] f_got, f_want;
    logic [11:0] fb [0:479][0:639];
    int          vlow = 0;
    int          last_fs = -1;
    int          fs_count = 0;

    task automatic monitor();
        logic [14:0] got, want;
        logic        efs;
        efs  = ntick && nh == 0 && nv == 480;
        got  = {hsync, vsync, vga_r, vga_g, vga_b, frame_start_o};
        want = {exp_hs, exp_vs, exp_rgb, efs};
        if (got !== want) begin
            if (line_err == 0) begin
                f_h = exp_h; f_got = got; f_want = want;
            end
            line_err++;
        end
        if (exp_tick) begin
            if (exp_h < 640 && exp_v < 480) fb[exp_v][exp_h] = {vga_r, vga_g, vga_b};
            if (vsync == 1'b0) vlow++;
        end
        if (frame_start_o === 1'b1) begin
            fs_count++;
            if (last_fs >= 0) begin
                checks++;
                if (cyc - last_fs != FRAME * DIV) begin
                    fails++;
                    $display("FAIL frame_start_period: got %0d cycles, want %0d", cyc - last_fs, FRAME * DIV);
                end
            end
            last_fs = cyc;
        end
        if (exp_tick && exp_h == 799) begin
            checks++;
            if (line_err != 0) begin
                fails++;
                $display("FAIL line_model v=%0d: %0d bad cycles, first h=%0d got hs/vs/rgb/fs=%b/%b/%h/%b want %b/%b/%h/%b",
                         exp_v, line_err, f_h, f_got[14], f_got[13], f_got[12:1], f_got[0],
                         f_want[14], f_want[13], f_want[12:1], f_want[0]);
            end
            line_err = 0;
            if (exp_v == 524) begin
                checks++;
                if (vlow != 1600) begin
                    fails++;
                    $display("FAIL vsync_low_ticks: got %0d, want 1600", vlow);
                end
                vlow = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (!reset) monitor();
    endtask

    task automatic wait_pixel(input int target, input bit rnd);
        int limit;
        int i;
        limit = (target + 4) * DIV + 10;
        i = 0;
        while (!(exp_tick && exp_q >= target) && i < limit) begin
            step();
            if (rnd && (cyc % 1013 == 0)) board_i = rand256();
            i++;
        end
        checks++;
        if (!(exp_tick && exp_q >= target)) begin
            fails++;
            $display("FAIL wait_pixel: got pixel %0d after %0d cycles, want %0d", exp_q, i, target);
        end
    endtask

    task automatic wait_hs(input logic lvl, output int t);
        int i;
        i = 0;
        while (hsync !== lvl && i < 1000 * DIV) begin
            step();
            i++;
        end
        t = cyc;
        checks++;
        if (hsync !== lvl) begin
            fails++;
            $display("FAIL hsync_wait: got %b, want %b", hsync, lvl);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({hsync, vsync, vga_r, vga_g, vga_b, frame_start_o} !== {1'b1, 1'b1, 12'h000, 1'b0}) begin
            fails++;
            $display("FAIL %s: got hs/vs/rgb/fs=%b/%b/%h/%b, want 1/1/000/0",
                     name, hsync, vsync, {vga_r, vga_g, vga_b}, frame_start_o);
        end
    endtask

    task automatic release_reset();
        reset     = 1'b0;
        line_err  = 0;
        vlow      = 0;
        last_fs   = -1;
        fs_count  = 0;
    endtask

    typedef struct {
        int          x;
        int          y;
        logic [11:0] want;
        bit          on_grid;
    } probe_t;

    probe_t tab1[13];
    probe_t tab2[7];

    task automatic run_probes(input string name, input probe_t p);
        logic [11:0] want;
        want = (GRID && p.on_grid) ? 12'h444 : p.want;
        checks++;
        if (fb[p.y][p.x] !== want) begin
            fails++;
            $display("FAIL %s (%0d,%0d): got %h, want %h", name, p.x, p.y, fb[p.y][p.x], want);
        end
    endtask

    initial begin
        int t0, tf, tr, tf2;
        logic [255:0] pat;

        tab1[0]  = '{128, 48,  12'h0F0, 1'b1};
        tab1[1]  = '{129, 49,  12'h0F0, 1'b0};
        tab1[2]  = '{151, 71,  12'h0F0, 1'b0};
        tab1[3]  = '{140, 60,  12'h0F0, 1'b0};
        tab1[4]  = '{152, 48,  12'h111, 1'b1};
        tab1[5]  = '{127, 48,  12'h004, 1'b0};
        tab1[6]  = '{488, 408, 12'h0F0, 1'b1};
        tab1[7]  = '{511, 431, 12'h0F0, 1'b0};
        tab1[8]  = '{512, 408, 12'h004, 1'b0};
        tab1[9]  = '{487, 408, 12'h111, 1'b1};
        tab1[10] = '{300, 200, 12'h111, 1'b0};
        tab1[11] = '{128, 432, 12'h004, 1'b0};
        tab1[12] = '{600, 10,  12'h004, 1'b0};

        tab2[0] = '{133, 53,  12'h0F0, 1'b0};
        tab2[1] = '{511, 431, 12'h0F0, 1'b0};
        tab2[2] = '{300, 200, 12'h0F0, 1'b0};
        tab2[3] = '{127, 200, 12'h004, 1'b0};
        tab2[4] = '{512, 431, 12'h004, 1'b0};
        tab2[5] = '{300, 432, 12'h004, 1'b0};
        tab2[6] = '{130, 47,  12'h004, 1'b0};

        repeat (3) step();
        check_idle("reset_state");
        release_reset();

        // First frame after reset: random board changes must never show (snapshot still zero).
        wait_pixel(200 * 800, 1'b1);
        reset = 1'b1;
        #1;
        check_idle("reset_midframe");
        repeat (3) step();
        check_idle("reset_held");
        release_reset();

        t0 = cyc;
        wait_hs(1'b0, tf);
        wait_hs(1'b1, tr);
        wait_hs(1'b0, tf2);
        checks++;
        if (tf - (t0 + DIV) != 656 * DIV) begin
            fails++;
            $display("FAIL hsync_fall: got %0d cycles after line start, want %0d", tf - (t0 + DIV), 656 * DIV);
        end
        checks++;
        if (tr - tf != 96 * DIV) begin
            fails++;
            $display("FAIL hsync_width: got %0d, want %0d", tr - tf, 96 * DIV);
        end
        checks++;
        if (tf2 - tf != 800 * DIV) begin
            fails++;
            $display("FAIL line_period: got %0d, want %0d", tf2 - tf, 800 * DIV);
        end

        wait_pixel(470 * 800, 1'b1);
        pat = rand256();
        pat[0] = 1'b1; pat[255] = 1'b1;
        pat[1] = 1'b0; pat[254] = 1'b0; pat[103] = 1'b0;
        board_i = pat;

        // Change the board mid-frame; the frame being drawn must keep the old snapshot.
        wait_pixel(FRAME + 100 * 800, 1'b0);
        board_i = {256{1'b1}};
        wait_pixel(FRAME + 450 * 800, 1'b0);
        for (int i = 0; i < 13; i++) run_probes("probe_frame1", tab1[i]);

        wait_pixel(2 * FRAME + 450 * 800, 1'b0);
        for (int i = 0; i < 7; i++) run_probes("probe_frame2", tab2[i]);

        checks++;
        if (fs_count != 2) begin
            fails++;
            $display("FAIL frame_start_count: got %0d, want 2", fs_count);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
